// File: rtl/wf_window_ctrl.sv
// wf_window_ctrl: per-channel horizontal zoom/pan window and vertical lane
// selection for a multi-channel waveform display, driven by four buttons.
// Optional feature: define WF_AUTO_REPEAT_EN to enable hold-to-repeat on the
// pan buttons (IDLE -> HOLD -> REPEAT); otherwise every button is edge-only.
module wf_window_ctrl #(
    parameter int X_W           = 11,
    parameter int Y_W           = 10,
    parameter int SCREEN_W      = 1280,
    parameter int SCREEN_H      = 720,
    parameter int NUM_CH        = 2,
    parameter int ZOOM_LVLS     = 4,
    parameter int PAN_STEP      = 16,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         btn_left,
    input  logic                                         btn_right,
    input  logic                                         btn_zoom,
    input  logic                                         btn_ch,
    output logic [X_W-1:0]                               start_x,
    output logic [X_W-1:0]                               end_x,
    output logic [Y_W-1:0]                               start_y,
    output logic [Y_W-1:0]                               end_y,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic                                         changed
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ZW   = (ZOOM_LVLS > 1) ? $clog2(ZOOM_LVLS) : 1;
    localparam int XS   = X_W + 2;
    localparam int LANE = SCREEN_H / NUM_CH;

    localparam logic signed [XS-1:0] SW_S    = XS'(SCREEN_W);
    localparam logic signed [XS-1:0] STEP_S  = XS'(PAN_STEP);
    localparam logic [ZW-1:0]        Z_LAST  = ZW'(ZOOM_LVLS - 1);
    localparam logic [CH_W-1:0]      CH_LAST = CH_W'(NUM_CH - 1);

    // Button order in vectors: [3]=ch, [2]=zoom, [1]=right, [0]=left
    logic [3:0] btn_vec;
    logic [3:0] btn_prev_q, btn_prev_d;
    logic [3:0] btn_rise;
    logic [1:0] pan_act;

    // Rising-edge detection on all buttons
    always_comb begin
        btn_vec    = {btn_ch, btn_zoom, btn_right, btn_left};
        btn_prev_d = btn_vec;
        btn_rise   = btn_vec & ~btn_prev_q;
    end

    // Previous-level register; reset to 1 so a button held through reset needs a fresh press
    always_ff @(posedge clk) begin
        if (rst) btn_prev_q <= '1;
        else     btn_prev_q <= btn_prev_d;
    end

`ifdef WF_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    typedef enum logic [1:0] {RPT_IDLE, RPT_HOLD, RPT_REPEAT} rpt_state_e;

    rpt_state_e       pan_st_q  [2];
    rpt_state_e       pan_st_d  [2];
    logic [CNT_W-1:0] pan_cnt_q [2];
    logic [CNT_W-1:0] pan_cnt_d [2];

    // Pan auto-repeat FSMs: press action, one after REPEAT_DELAY, then every REPEAT_PERIOD
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            pan_st_d[i]  = pan_st_q[i];
            pan_cnt_d[i] = pan_cnt_q[i];
            pan_act[i]   = 1'b0;
            case (pan_st_q[i])
                RPT_IDLE: begin
                    if (btn_rise[i]) begin
                        pan_act[i]   = 1'b1;
                        pan_st_d[i]  = RPT_HOLD;
                        pan_cnt_d[i] = '0;
                    end
                end
                RPT_HOLD: begin
                    if (!btn_vec[i]) begin
                        pan_st_d[i] = RPT_IDLE;
                    end else if (pan_cnt_q[i] == CNT_W'(REPEAT_DELAY - 1)) begin
                        pan_act[i]   = 1'b1;
                        pan_st_d[i]  = RPT_REPEAT;
                        pan_cnt_d[i] = '0;
                    end else begin
                        pan_cnt_d[i] = pan_cnt_q[i] + CNT_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!btn_vec[i]) begin
                        pan_st_d[i] = RPT_IDLE;
                    end else if (pan_cnt_q[i] == CNT_W'(REPEAT_PERIOD - 1)) begin
                        pan_act[i]   = 1'b1;
                        pan_cnt_d[i] = '0;
                    end else begin
                        pan_cnt_d[i] = pan_cnt_q[i] + CNT_W'(1);
                    end
                end
                default: pan_st_d[i] = RPT_IDLE;
            endcase
        end
    end

    // Pan FSM state and counters
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (rst) begin
                pan_st_q[i]  <= RPT_IDLE;
                pan_cnt_q[i] <= '0;
            end else begin
                pan_st_q[i]  <= pan_st_d[i];
                pan_cnt_q[i] <= pan_cnt_d[i];
            end
        end
    end
`else
    // Pan actions on rising edge only
    always_comb begin
        pan_act = btn_rise[1:0];
    end
`endif

    logic [ZW-1:0]          z_q  [NUM_CH];
    logic [ZW-1:0]          z_d  [NUM_CH];
    logic [X_W-1:0]         sx_q [NUM_CH];
    logic [X_W-1:0]         sx_d [NUM_CH];
    logic [CH_W-1:0]        ch_sel_q, ch_sel_d;
    logic [ZW-1:0]          cur_z, new_z;
    logic signed [XS-1:0]   cur_sx, cur_w, new_w, centre, cand, limit;

    // Apply the highest-priority action (ch > zoom > pan) to the selected channel
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            z_d[i]  = z_q[i];
            sx_d[i] = sx_q[i];
        end
        ch_sel_d = ch_sel_q;
        cur_z    = z_q[ch_sel_q];
        cur_sx   = {2'b00, sx_q[ch_sel_q]};
        cur_w    = SW_S >> cur_z;
        new_z    = (cur_z == Z_LAST) ? '0 : cur_z + ZW'(1);
        new_w    = SW_S >> new_z;
        centre   = cur_sx + (cur_w >>> 1);
        cand     = cur_sx;
        limit    = SW_S - cur_w;

        if (btn_rise[3]) begin
            ch_sel_d = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + CH_W'(1);
        end else if (btn_rise[2]) begin
            // Re-centre on the old window centre, then clamp to the new width's range
            cand  = centre - (new_w >>> 1);
            limit = SW_S - new_w;
            if (cand[XS-1])        cand = '0;
            else if (cand > limit) cand = limit;
            z_d[ch_sel_q]  = new_z;
            sx_d[ch_sel_q] = cand[X_W-1:0];
        end else if (pan_act == 2'b01) begin
            cand = cur_sx - STEP_S;
            if (cand[XS-1]) cand = '0;
            sx_d[ch_sel_q] = cand[X_W-1:0];
        end else if (pan_act == 2'b10) begin
            cand = cur_sx + STEP_S;
            if (cand > limit) cand = limit;
            sx_d[ch_sel_q] = cand[X_W-1:0];
        end
    end

    logic [X_W-1:0]       start_x_q, start_x_d, end_x_q, end_x_d;
    logic [Y_W-1:0]       start_y_q, start_y_d, end_y_q, end_y_d;
    logic                 changed_q, changed_d;
    logic [ZW-1:0]        out_z;
    logic signed [XS-1:0] out_w;

    // Next output values from the next state, so outputs land one cycle after the action
    always_comb begin
        out_z     = z_d[ch_sel_d];
        out_w     = SW_S >> out_z;
        start_x_d = sx_d[ch_sel_d];
        end_x_d   = start_x_d + out_w[X_W-1:0] - X_W'(1);
        start_y_d = Y_W'(LANE * int'(ch_sel_d));
        end_y_d   = start_y_d + Y_W'(LANE - 1);
        changed_d = (start_x_d != start_x_q) || (end_x_d != end_x_q) ||
                    (start_y_d != start_y_q) || (end_y_d != end_y_q) ||
                    (ch_sel_d != ch_sel_q);
    end

    // Channel state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                z_q[i]  <= '0;
                sx_q[i] <= '0;
            end
            ch_sel_q  <= '0;
            start_x_q <= '0;
            end_x_q   <= X_W'(SCREEN_W - 1);
            start_y_q <= '0;
            end_y_q   <= Y_W'(LANE - 1);
            changed_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                z_q[i]  <= z_d[i];
                sx_q[i] <= sx_d[i];
            end
            ch_sel_q  <= ch_sel_d;
            start_x_q <= start_x_d;
            end_x_q   <= end_x_d;
            start_y_q <= start_y_d;
            end_y_q   <= end_y_d;
            changed_q <= changed_d;
        end
    end

    assign start_x = start_x_q;
    assign end_x   = end_x_q;
    assign start_y = start_y_q;
    assign end_y   = end_y_q;
    assign ch_sel  = ch_sel_q;
    assign changed = changed_q;

endmodule
